// File: rtl/packet_tx.sv
// packet_tx: BEEF packet transmitter, input byte FIFO plus framing FSM.
// Optional error injection is compiled in with PKT_TX_ERR_INJECT_EN.
module packet_tx #(
   parameter int         FIFO_DEPTH = 16,
   parameter int         MIN_GAP    = 0,
   parameter logic [7:0] IDLE_BYTE  = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
`ifdef PKT_TX_ERR_INJECT_EN
   input  logic [1:0] inject_err,
`endif
   output logic       tx_valid,
   output logic [7:0] tx_data,
   output logic       tx_sop,
   output logic       tx_eop,
   output logic       sub_err,
   output logic       adj_flag
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
   localparam logic [7:0] SYNC0 = 8'hBE;
   localparam logic [7:0] SYNC1 = 8'hEF;

   typedef enum logic [2:0] {
      IDLE, LOAD, HDR0, HDR1, BODY, CSUM, GAP
   } state_t;

   state_t        state;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   logic [7:0]    wr_byte;
   logic [7:0]    rd_byte;
   logic [7:0]    body [8];
   logic [2:0]    cnt;
   logic [7:0]    sum;
   logic          adj;
   logic          dup;
   logic [GW-1:0] gap_cnt;
   logic [7:0]    sum_nx;
   logic [7:0]    fix_amt;
   logic [7:0]    b7_fix;
   logic [7:0]    sum_fix;
   logic [7:0]    csum_tx;
   logic [2:0]    last_idx;
   logic [1:0]    inj;
   logic          start;

   function automatic logic is_sync(input logic [7:0] b);
      return (b == SYNC0) || (b == SYNC1);
   endfunction

   assign in_ready = count < CW'(FIFO_DEPTH);
   assign push     = in_valid & in_ready;
   assign pop      = (state == LOAD);
   assign wr_byte  = is_sync(in_data) ? 8'h00 : in_data;
   assign rd_byte  = mem[rd_ptr];
   assign start    = (state == IDLE) && (count >= CW'(8));

`ifdef PKT_TX_ERR_INJECT_EN
   // Latch the injection mode once per packet, at the IDLE->LOAD step.
   always_ff @(posedge clk) begin
      if (reset)
         inj <= 2'b00;
      else if (start)
         inj <= inject_err;
   end
`else
   assign inj = 2'b00;
`endif

   // Running sum, last-byte fix-up that keeps sync bytes off the checksum.
   always_comb begin
      sum_nx  = sum + rd_byte;
      fix_amt = 8'd0;
      if (is_sync(sum_nx))
         fix_amt = is_sync(rd_byte + 8'd1) ? 8'd2 : 8'd1;
      b7_fix  = rd_byte + fix_amt;
      sum_fix = sum_nx + fix_amt;
      csum_tx = sum;
      if (inj == 2'b01)
         csum_tx = is_sync(sum + 8'd1) ? sum + 8'd2 : sum + 8'd1;
      last_idx = (inj == 2'b10) ? 3'd6 : 3'd7;
   end

   // Input FIFO with sync-byte substitution and occupancy count.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         sub_err <= 1'b0;
      end else begin
         sub_err <= push & is_sync(in_data);
         if (push) begin
            mem[wr_ptr] <= wr_byte;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // Framing FSM; outputs are registered alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 3'd0;
         sum      <= 8'd0;
         adj      <= 1'b0;
         dup      <= 1'b0;
         gap_cnt  <= '0;
         tx_valid <= 1'b0;
         tx_data  <= IDLE_BYTE;
         tx_sop   <= 1'b0;
         tx_eop   <= 1'b0;
         adj_flag <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD;
                  cnt   <= 3'd0;
                  sum   <= 8'd0;
                  adj   <= 1'b0;
                  dup   <= 1'b0;
               end
            end
            LOAD: begin
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  body[7]  <= b7_fix;
                  sum      <= sum_fix;
                  adj      <= (fix_amt != 8'd0);
                  state    <= HDR0;
                  tx_valid <= 1'b1;
                  tx_data  <= SYNC0;
                  tx_sop   <= 1'b1;
               end else begin
                  body[cnt] <= rd_byte;
                  sum       <= sum_nx;
               end
            end
            HDR0: begin
               state   <= HDR1;
               tx_sop  <= 1'b0;
               tx_data <= SYNC1;
            end
            HDR1: begin
               state   <= BODY;
               cnt     <= 3'd0;
               tx_data <= body[0];
            end
            BODY: begin
               if (cnt == last_idx) begin
                  if ((inj == 2'b11) && !dup) begin
                     dup     <= 1'b1;
                     tx_data <= body[cnt];
                  end else begin
                     state    <= CSUM;
                     tx_data  <= csum_tx;
                     tx_eop   <= 1'b1;
                     adj_flag <= adj;
                  end
               end else begin
                  cnt     <= cnt + 3'd1;
                  tx_data <= body[cnt + 3'd1];
               end
            end
            CSUM: begin
               tx_valid <= 1'b0;
               tx_data  <= IDLE_BYTE;
               tx_eop   <= 1'b0;
               adj_flag <= 1'b0;
               gap_cnt  <= '0;
               state    <= (MIN_GAP > 0) ? GAP : IDLE;
            end
            GAP: begin
               gap_cnt <= gap_cnt + GW'(1);
               if (gap_cnt == GAP_LAST)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
